cache_mem_responder: RTL and testbench
======================================

// Module: cache_mem_responder
// PURPOSE
// - Memory-side responder for the cache fill FSM: accepts word reads/writes, returns read data after a fixed LATENCY.
// - Read data is returned on memory_data, qualified by a one-cycle memory_data_valid pulse.
// - Reads are fully pipelined: one new read may be accepted every cycle, and in-flight reads never stall.
// - Sits between the I/D cache fill FSMs (via the arbiter) and main memory storage.
// PARAMETERS
// - ADDR_W   16  byte-address width
// - DATA_W   16  word width
// - MEM_AW   10  log2 of words stored; array depth = 2**MEM_AW
// - LATENCY  4   read latency in cycles; legal range >= 1
// - CNT_W    3   width of the in-flight counter; must satisfy 2**CNT_W > LATENCY
// PORTS
// - clk                 in   1       clock; all state updates on the rising edge
// - rst_n               in   1       synchronous, active-low reset
// - read_request        in   1       read strobe, sampled each edge
// - write_request       in   1       write strobe, sampled each edge
// - memory_address      in   ADDR_W  byte address; bit 0 ignored
// - write_data          in   DATA_W  data to write
// - memory_data         out  DATA_W  returned read data
// - memory_data_valid   out  1       memory_data holds a read result this cycle
// - in_flight           out  CNT_W   count of accepted reads not yet returned
// - mem_busy            out  1       high when in_flight != 0
// BEHAVIOUR
// - Array index = memory_address[MEM_AW:1]; higher address bits are ignored (aliasing).
// - Array contents are not reset.
// - Write: write_request high at edge E stores write_data into array[idx] at E.
// - Read acceptance: read_request high at edge E0 accepts a read.
//   - Data captured = array value before any write at E0 (read-old).
// - Simultaneous read and write: both requests high at E0 is legal.
//   - The read returns the pre-write value; the write still commits.
// - Pipeline: LATENCY stages of {valid, data}.
//   - Stage 0 loads at E0; every stage shifts every edge.
//   - Stage LATENCY-1 drives the outputs.
// - Timing: memory_data_valid is high for exactly the cycle after edge E0+LATENCY-1.
//   - The consumer samples it at edge E0+LATENCY. LATENCY=4 gives the 4-cycle fill-chunk latency.
// - Back-to-back reads on N consecutive edges give N consecutive valid cycles, in request order.
// - A read with no new request behind it gives a single-cycle valid pulse.
// - memory_data = 0 whenever memory_data_valid = 0.
// - in_flight update per edge:
//   - +1 on an accepted read; -1 when stage LATENCY-1 is valid.
//   - Both in the same edge leaves it unchanged.
//   - It never wraps by construction.
// - mem_busy = (in_flight != 0), combinational from in_flight.
// - Reset: rst_n low at an edge clears all stage valids/data, memory_data, memory_data_valid and in_flight to 0.
// - Reset mid-operation: in-flight reads are discarded; no valid pulses follow from requests accepted before reset.
// - Requests sampled while rst_n is low are ignored, including writes, which do not commit.
// - LATENCY=1: valid is high the cycle after the accepting edge.
// TESTING
// - Write/read: write 16'hBEEF @ 16'h0040, then a read of 16'h0040 at E0.
//   -> valid only in the cycle after E0+3, memory_data=16'hBEEF.
// - Fill burst: 8 reads on consecutive edges, addresses 16'h1230..16'h123E step 2, preloaded with 1..8.
//   -> 8 contiguous valid cycles returning 1..8.
//   -> in_flight peaks at 4 (LATENCY) and ends at 0.
// - Fill-FSM pacing: one read every 4 cycles for 8 chunks.
//   -> 8 isolated single-cycle valid pulses, each aligned with the next request edge.
//   -> mem_busy drops after the last return.
// - Read/write collision: array[16'h0010]=16'h1111; read + write 16'h2222 @ 16'h0010 at the same edge.
//   -> returns 16'h1111; a later read returns 16'h2222.
// - Reset mid-burst: assert rst_n=0 for one edge with 3 reads in flight.
//   -> no valid pulses afterwards, in_flight=0, memory_data=0.
// - Aliasing/odd address: write at 16'h0041 (bit 0 set); read 16'h0040 and 16'h0040 + 2**(MEM_AW+1).
//   -> both reads return the written value.

Source files
------------

// File: rtl/cache_mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_mem_responder_if                                          |
// | Purpose  : Request/response bundle between the cache fill arbiter (master) |
// |            and the memory responder (slave).                               |
// | Signals  : read_request, write_request, memory_address, write_data  (m->s) |
// |            memory_data, memory_data_valid, in_flight, mem_busy      (s->m) |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface cache_mem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 3
);
  logic              read_request;
  logic              write_request;
  logic [ADDR_W-1:0] memory_address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;
  logic [CNT_W-1:0]  in_flight;
  logic              mem_busy;

  modport master (
    output read_request, write_request, memory_address, write_data,
    input  memory_data, memory_data_valid, in_flight, mem_busy
  );

  modport slave (
    input  read_request, write_request, memory_address, write_data,
    output memory_data, memory_data_valid, in_flight, mem_busy
  );
endinterface
`default_nettype wire

// File: rtl/cache_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_mem_responder                                             |
// | Purpose  : Word-addressed memory behind the cache fill FSMs. Writes commit |
// |            at the sampling edge; reads are fully pipelined and return     |
// |            after LATENCY cycles with a one-cycle memory_data_valid pulse. |
// | Ports    : clk    - clock, rising edge                                     |
// |            rst_n  - synchronous active-low reset                           |
// |            bus    - cache_mem_responder_if.slave (requests in, data out)  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cache_mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_AW  = 10,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 3
) (
  input  wire                   clk,
  input  wire                   rst_n,
  cache_mem_responder_if.slave  bus
);

  // Word index: byte-address bit 0 is dropped, bits above MEM_AW alias.
  logic [MEM_AW-1:0] idx;
  assign idx = bus.memory_address[MEM_AW:1];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.memory_address[0], bus.memory_address[ADDR_W-1:MEM_AW+1]};

  // Storage is intentionally not reset.
  logic [DATA_W-1:0] mem [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (rst_n && bus.write_request) begin
      mem[idx] <= bus.write_data;
    end
  end

  // Read pipeline. Stage 0 samples the array with a non-blocking read, so a
  // same-edge write is not yet visible (read-old). Data in an empty stage is
  // kept at zero so the output needs no extra gating.
  logic [LATENCY-1:0]             stage_valid;
  logic [LATENCY-1:0][DATA_W-1:0] stage_data;
  logic [CNT_W-1:0]               in_flight;
  logic                           retire;

  assign retire = stage_valid[LATENCY-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid <= '0;
      stage_data  <= '0;
      in_flight   <= '0;
    end else begin
      stage_valid[0] <= bus.read_request;
      stage_data[0]  <= bus.read_request ? mem[idx] : '0;
      for (int i = LATENCY - 1; i > 0; i--) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
      // Accept and retire in the same edge cancel out.
      unique case ({bus.read_request, retire})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign bus.memory_data_valid = stage_valid[LATENCY-1];
  assign bus.memory_data       = stage_data[LATENCY-1];
  assign bus.in_flight         = in_flight;
  assign bus.mem_busy          = (in_flight != '0);

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cache_mem_responder                                          |
// | Purpose  : Scoreboard bench for cache_mem_responder. Each accepted read   |
// |            pushes its expected data and return cycle; a negedge monitor   |
// |            pops and compares on every valid pulse and checks idle state.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cache_mem_responder;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int MEM_AW  = 10;
  localparam int LATENCY = 4;
  localparam int CNT_W   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  cache_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW),
    .LATENCY(LATENCY), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t              scb[$];
  logic [DATA_W-1:0] model [int];
  int                cyc = 0;
  int                n_cmp = 0;
  int                n_err = 0;
  int                peak = 0;
  logic              mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, then account for what the edge accepted.
  task automatic step(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wd, input logic rn);
    int i;
    exp_t e;
    @(negedge clk);
    bus.read_request   = rd;
    bus.write_request  = wr;
    bus.memory_address = addr;
    bus.write_data     = wd;
    rst_n              = rn;
    @(posedge clk);
    #1;
    if (!rn) begin
      scb.delete();
    end else begin
      i = int'(addr[MEM_AW:1]);
      if (rd) begin
        e.data = model[i];
        e.due  = cyc + LATENCY - 1;
        scb.push_back(e);
      end
      if (wr) model[i] = wd;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    step(1'b0, 1'b1, a, d, 1'b1);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    step(1'b1, 1'b0, a, '0, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && scb.size() != 0; k++) idle(1);
    idle(2);
    check_eq("drain", scb.size(), 0);
  endtask

  // Monitor: outputs settle after posedge, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      check_eq("in_flight", 32'(bus.in_flight), scb.size());
      check_eq("mem_busy", 32'(bus.mem_busy), 32'(scb.size() != 0));
      if (int'(bus.in_flight) > peak) peak = int'(bus.in_flight);
      if (bus.memory_data_valid) begin
        if (scb.size() == 0) begin
          check_eq("unexpected_valid", 32'(bus.memory_data_valid), 0);
        end else begin
          e = scb.pop_front();
          check_eq("valid_cycle", cyc, e.due);
          check_eq("rdata", 32'(bus.memory_data), 32'(e.data));
        end
      end else begin
        check_eq("idle_data", 32'(bus.memory_data), 0);
        if (scb.size() != 0 && scb[0].due <= cyc) begin
          check_eq("missing_valid", 32'(bus.memory_data_valid), 1);
          e = scb.pop_front();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.read_request   = 1'b0;
    bus.write_request  = 1'b0;
    bus.memory_address = '0;
    bus.write_data     = '0;
    step(1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    check_eq("rst_valid", 32'(bus.memory_data_valid), 0);
    check_eq("rst_data", 32'(bus.memory_data), 0);
    check_eq("rst_in_flight", 32'(bus.in_flight), 0);
    mon_en = 1'b1;
    idle(1);

    // Basic write then read.
    wr(16'h0040, 16'hBEEF);
    rd(16'h0040);
    drain();

    // Fill burst: 8 back-to-back reads.
    for (int k = 0; k < 8; k++) wr(16'h1230 + 16'(2 * k), 16'(k + 1));
    idle(1);
    peak = 0;
    for (int k = 0; k < 8; k++) rd(16'h1230 + 16'(2 * k));
    drain();
    check_eq("burst_peak", peak, LATENCY);

    // Fill-FSM pacing: one read every 4 cycles.
    for (int k = 0; k < 8; k++) begin
      rd(16'h1230 + 16'(2 * (7 - k)));
      idle(3);
    end
    drain();

    // Same-edge read and write returns the old value.
    wr(16'h0010, 16'h1111);
    step(1'b1, 1'b1, 16'h0010, 16'h2222, 1'b1);
    rd(16'h0010);
    drain();

    // Reset with 3 reads in flight; a write during reset must not commit.
    wr(16'h0100, 16'h5555);
    rd(16'h1230);
    rd(16'h1232);
    rd(16'h1234);
    step(1'b1, 1'b1, 16'h0100, 16'hDEAD, 1'b0);
    #1;
    check_eq("rst_mid_in_flight", 32'(bus.in_flight), 0);
    check_eq("rst_mid_data", 32'(bus.memory_data), 0);
    idle(LATENCY + 2);
    rd(16'h0100);
    drain();

    // Odd address and aliasing above the array depth.
    wr(16'h0041, 16'hA5C3);
    rd(16'h0040);
    rd(16'h0040 + 16'(2 ** (MEM_AW + 1)));
    drain();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
